// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
//   Shares one VGA adapter write port between three pixel producers:
//   requester 0 = screen clear, 1 = tile draw, 2 = score draw.
//
// Handshake: a requester raises req[i] and holds it while it wants the port.
//   grant[i] tells it that it owns the port. It finishes by pulsing done[i]
//   or by dropping req[i]. The port is also taken back if it is held for
//   TIMEOUT cycles. Done and req changes from non-owners have no effect.
//
// Ports
//   clock, resetn            rising-edge clock, asynchronous active-low reset
//   req[2:0], done[2:0]      per-requester request / completion strobe
//   x_in[26:0]               packed 9-bit x per requester
//   y_in[23:0]               packed 8-bit y per requester
//   colour_in[8:0]           packed 3-bit colour per requester
//   plot_in[2:0]             per-requester pixel write enable
//   grant[2:0]               one-hot owner, or zero
//   vga_x/vga_y/vga_colour   registered pixel data of the owner
//   vga_plot                 registered, clipped write enable
//   timeout_flag             sticky, set on any forced release
//   state_dbg[1:0]           FSM state (0 idle, 1 hold, 2 gap)
module vga_plot_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd32768
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [2:0]  req,
  input  logic [2:0]  done,
  input  logic [26:0] x_in,
  input  logic [23:0] y_in,
  input  logic [8:0]  colour_in,
  input  logic [2:0]  plot_in,
  output logic [2:0]  grant,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        timeout_flag,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic        rr_q, rr_d;        // 0: tile favoured, 1: score favoured
  logic [15:0] cnt_q, cnt_d;
  logic        tflag_q, tflag_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [2:0]  col_q, col_d;
  logic        plot_q, plot_d;

  logic [2:0]  win_oh;
  logic        owner_release;
  logic        force_rel;
  logic [8:0]  own_x;
  logic [7:0]  own_y;
  logic [2:0]  own_c;
  logic        own_p;

  // Winner: clear always first; tile/score share via the round-robin bit.
  always_comb begin
    win_oh = 3'b000;
    if (req[0])                 win_oh = 3'b001;
    else if (req[1] && req[2])  win_oh = rr_q ? 3'b100 : 3'b010;
    else if (req[1])            win_oh = 3'b010;
    else if (req[2])            win_oh = 3'b100;
  end

  // Owner field select, driven by the registered grant.
  always_comb begin
    own_x = x_in[8:0];
    own_y = y_in[7:0];
    own_c = colour_in[2:0];
    own_p = plot_in[0];
    if (grant_q[1]) begin
      own_x = x_in[17:9];
      own_y = y_in[15:8];
      own_c = colour_in[5:3];
      own_p = plot_in[1];
    end else if (grant_q[2]) begin
      own_x = x_in[26:18];
      own_y = y_in[23:16];
      own_c = colour_in[8:6];
      own_p = plot_in[2];
    end
  end

  // Only meaningful in HOLD. Done from the owner and a dropped owner request
  // release the port identically; done beats a simultaneous timeout.
  assign owner_release = (|(grant_q & done)) | ~(|(grant_q & req));
  assign force_rel     = (state_q == S_HOLD) && !owner_release &&
                         (cnt_q == TIMEOUT - 16'd1);

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      grant_q <= 3'b000;
      rr_q    <= 1'b0;
      cnt_q   <= 16'd0;
      tflag_q <= 1'b0;
      x_q     <= 9'd0;
      y_q     <= 8'd0;
      col_q   <= 3'd0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
    end
  end

  // Next-state logic. GAP is the single grant-free cycle after a release;
  // it arbitrates exactly like IDLE, so back-to-back owners see one zero
  // cycle of grant between them.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    tflag_d = tflag_q;
    case (state_q)
      S_HOLD: begin
        if (owner_release) begin
          state_d = S_GAP;
          grant_d = 3'b000;
        end else if (force_rel) begin
          state_d = S_GAP;
          grant_d = 3'b000;
          tflag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        if (|req) begin
          state_d = S_HOLD;
          grant_d = win_oh;
          cnt_d   = 16'd0;
          if (win_oh[1])      rr_d = 1'b1;
          else if (win_oh[2]) rr_d = 1'b0;
        end else begin
          state_d = S_IDLE;
          grant_d = 3'b000;
        end
      end
    endcase
  end

  // Output logic: pixel path follows the owner, clipped to 320x240.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    col_d  = col_q;
    plot_d = 1'b0;
    if ((state_q == S_HOLD) && !force_rel) begin
      x_d    = own_x;
      y_d    = own_y;
      col_d  = own_c;
      plot_d = own_p && (own_x < 9'd320) && (own_y < 8'd240);
    end
  end

  assign grant        = grant_q;
  assign vga_x        = x_q;
  assign vga_y        = y_q;
  assign vga_colour   = col_q;
  assign vga_plot     = plot_q;
  assign timeout_flag = tflag_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
module tb_vga_plot_arbiter;

  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  done = '0;
  logic [26:0] x_in = '0;
  logic [23:0] y_in = '0;
  logic [8:0]  colour_in = '0;
  logic [2:0]  plot_in = '0;
  logic [2:0]  grant;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        timeout_flag;
  logic [1:0]  state_dbg;

  always #5 clock = ~clock;

  vga_plot_arbiter #(.TIMEOUT(16'd16)) dut (
    .clock(clock), .resetn(resetn), .req(req), .done(done),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .plot_in(plot_in),
    .grant(grant), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .timeout_flag(timeout_flag), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req       = '0;
    done      = '0;
    x_in      = '0;
    y_in      = '0;
    colour_in = '0;
    plot_in   = '0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic set_fields(input int i, input logic [8:0] x, input logic [7:0] y,
                            input logic [2:0] c);
    x_in[i*9 +: 9]      = x;
    y_in[i*8 +: 8]      = y;
    colour_in[i*3 +: 3] = c;
  endtask

  // ---------------- reference model ----------------
  // Owner as an integer (-1 = nobody), cycles already held, and which of
  // tile/score was granted most recently.
  int         m_owner;
  int         m_held;
  int         m_last_shared;
  logic       m_tflag;
  logic [8:0] m_x;
  logic [7:0] m_y;
  logic [2:0] m_c;
  logic       m_plot;

  task automatic model_reset();
    m_owner = -1;
    m_held = 0;
    m_last_shared = 2;   // as if score went last, so tile is favoured
    m_tflag = 1'b0;
    m_x = '0;
    m_y = '0;
    m_c = '0;
    m_plot = 1'b0;
  endtask

  task automatic model_take(input int o);
    m_x = x_in[o*9 +: 9];
    m_y = y_in[o*8 +: 8];
    m_c = colour_in[o*3 +: 3];
    m_plot = plot_in[o] && (int'(m_x) < 320) && (int'(m_y) < 240);
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    int w;
    if (m_owner >= 0) begin
      if (done[m_owner] || !req[m_owner]) begin
        model_take(m_owner);
        m_owner = -1;
      end else if (m_held + 1 == TO) begin
        m_plot = 1'b0;
        m_owner = -1;
        m_tflag = 1'b1;
      end else begin
        model_take(m_owner);
        m_held++;
      end
    end else begin
      m_plot = 1'b0;
      if (req != 3'b000) begin
        if (req[0])                w = 0;
        else if (req[1] && req[2]) w = (m_last_shared == 1) ? 2 : 1;
        else if (req[1])           w = 1;
        else                       w = 2;
        if (w != 0) m_last_shared = w;
        m_owner = w;
        m_held = 0;
      end
    end
  endtask

  function automatic logic [2:0] model_grant();
    return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
  endfunction

  task automatic check_model();
    check("rnd_grant",  32'(grant),        32'(model_grant()));
    check("rnd_x",      32'(vga_x),        32'(m_x));
    check("rnd_y",      32'(vga_y),        32'(m_y));
    check("rnd_colour", 32'(vga_colour),   32'(m_c));
    check("rnd_plot",   32'(vga_plot),     32'(m_plot));
    check("rnd_tflag",  32'(timeout_flag), 32'(m_tflag));
    check("rnd_onehot", 32'($onehot0(grant)), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] plot;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] exp_grant;
    logic       exp_plot;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int held;

    // Tile fields carry x/y; other requesters stay at zero.
    vecs[0]  = '{3'b111, 3'b000, 3'b000, 9'd0,   8'd0,   3'b001, 1'b0};
    vecs[1]  = '{3'b111, 3'b001, 3'b000, 9'd0,   8'd0,   3'b000, 1'b0};
    vecs[2]  = '{3'b110, 3'b000, 3'b000, 9'd0,   8'd0,   3'b010, 1'b0};
    vecs[3]  = '{3'b110, 3'b000, 3'b010, 9'd319, 8'd239, 3'b010, 1'b1};
    vecs[4]  = '{3'b110, 3'b000, 3'b010, 9'd320, 8'd239, 3'b010, 1'b0};
    vecs[5]  = '{3'b110, 3'b000, 3'b010, 9'd319, 8'd240, 3'b010, 1'b0};
    vecs[6]  = '{3'b110, 3'b000, 3'b010, 9'd0,   8'd0,   3'b010, 1'b1};
    vecs[7]  = '{3'b110, 3'b000, 3'b000, 9'd319, 8'd239, 3'b010, 1'b0};
    vecs[8]  = '{3'b110, 3'b010, 3'b010, 9'd5,   8'd6,   3'b000, 1'b1};
    vecs[9]  = '{3'b110, 3'b000, 3'b000, 9'd5,   8'd6,   3'b100, 1'b0};
    vecs[10] = '{3'b110, 3'b100, 3'b000, 9'd5,   8'd6,   3'b000, 1'b0};
    vecs[11] = '{3'b010, 3'b000, 3'b000, 9'd5,   8'd6,   3'b010, 1'b0};

    // Reset state
    do_reset();
    check("rst_grant",  32'(grant),        32'd0);
    check("rst_x",      32'(vga_x),        32'd0);
    check("rst_y",      32'(vga_y),        32'd0);
    check("rst_colour", 32'(vga_colour),   32'd0);
    check("rst_plot",   32'(vga_plot),     32'd0);
    check("rst_tflag",  32'(timeout_flag), 32'd0);

    // Table: priority, gap, round-robin and clipping
    for (int i = 0; i < 12; i++) begin
      req     = vecs[i].req;
      done    = vecs[i].done;
      plot_in = vecs[i].plot;
      set_fields(1, vecs[i].x, vecs[i].y, 3'd3);
      tick();
      check($sformatf("vec%0d_grant", i), 32'(grant),    32'(vecs[i].exp_grant));
      check($sformatf("vec%0d_plot", i),  32'(vga_plot), 32'(vecs[i].exp_plot));
    end

    // Tile and score alternate, each done after five cycles
    do_reset();
    req = 3'b110;
    for (int g = 0; g < 4; g++) begin
      logic [2:0] exp_g;
      exp_g = (g % 2 == 1) ? 3'b100 : 3'b010;
      tick();
      check($sformatf("alt%0d_entry", g), 32'(grant), 32'(exp_g));
      for (int k = 1; k < 5; k++) begin
        if (k == 4) done = exp_g;
        tick();
        check($sformatf("alt%0d_hold", g), 32'(grant), (k == 4) ? 32'd0 : 32'(exp_g));
      end
      done = 3'b000;
    end

    // Forced release after TIMEOUT cycles; flag is sticky
    do_reset();
    req = 3'b010;
    tick();
    check("to_entry", 32'(grant), 32'b010);
    held = 0;
    while (grant == 3'b010 && held < 40) begin
      held++;
      tick();
    end
    check("to_hold_cycles", 32'(held), 32'd16);
    check("to_flag_set", 32'(timeout_flag), 32'd1);
    check("to_plot_zero", 32'(vga_plot), 32'd0);
    tick();
    check("to_regrant", 32'(grant), 32'b010);
    check("to_flag_sticky", 32'(timeout_flag), 32'd1);
    req = 3'b000;
    tick();
    check("to_drop_grant", 32'(grant), 32'd0);
    check("to_flag_sticky2", 32'(timeout_flag), 32'd1);
    do_reset();
    check("to_flag_cleared", 32'(timeout_flag), 32'd0);

    // Clear request does not preempt an active score owner
    req = 3'b100;
    tick();
    check("np_entry", 32'(grant), 32'b100);
    req = 3'b101;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("np_hold", 32'(grant), 32'b100);
    end
    done = 3'b100;
    tick();
    check("np_gap", 32'(grant), 32'b000);
    done = 3'b000;
    tick();
    check("np_clear", 32'(grant), 32'b001);

    // Asynchronous reset mid-hold clears everything before the next edge
    do_reset();
    req = 3'b010;
    plot_in = 3'b010;
    set_fields(1, 9'd100, 8'd50, 3'd5);
    tick();
    check("ar_entry", 32'(grant), 32'b010);
    tick();
    check("ar_plot_on", 32'(vga_plot), 32'd1);
    check("ar_x", 32'(vga_x), 32'd100);
    check("ar_y", 32'(vga_y), 32'd50);
    check("ar_colour", 32'(vga_colour), 32'd5);
    #3 resetn = 1'b0;
    #1;
    check("ar_grant0",  32'(grant),      32'd0);
    check("ar_plot0",   32'(vga_plot),   32'd0);
    check("ar_x0",      32'(vga_x),      32'd0);
    check("ar_y0",      32'(vga_y),      32'd0);
    check("ar_colour0", 32'(vga_colour), 32'd0);
    #2 resetn = 1'b1;
    tick();
    check("ar_regrant", 32'(grant), 32'b010);
    check("ar_regrant_plot", 32'(vga_plot), 32'd0);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      model_step();
      tick();
      check_model();
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        done[i]    = ($urandom_range(0, 11) == 0);
        plot_in[i] = $urandom_range(0, 3) != 0;
        set_fields(i, 9'($urandom_range(300, 340)), 8'($urandom_range(225, 255)),
                   3'($urandom_range(0, 7)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
